// File: rtl/hazard_ctrl.sv
// Hazard controller for the five-stage F/D/E/M/W pipeline.
// Detects D-stage read-after-write hazards against E/M results that are not
// ready yet, drives the front-end freeze and the D->E bubble, selects the
// forwarding sources, sequences the multi-cycle MDU busy window and counts
// stall cycles. Every combinational output reads 0 while reset_n is low.
module hazard_ctrl #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10,
    parameter int unsigned CNT_W       = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ifReGrf1_D,
    input  logic        ifReGrf2_D,
    input  logic [4:0]  grfRa1_D,
    input  logic [4:0]  grfRa2_D,
    input  logic [4:0]  tUseRs_D,
    input  logic [4:0]  tUseRt_D,
    input  logic        ifReGrf1_E,
    input  logic        ifReGrf2_E,
    input  logic [4:0]  grfRa1_E,
    input  logic [4:0]  grfRa2_E,
    input  logic [4:0]  grfRa2_M,
    input  logic        ifWrGrf_E,
    input  logic        ifWrGrf_M,
    input  logic        ifWrGrf_W,
    input  logic [4:0]  grfWa_E,
    input  logic [4:0]  grfWa_M,
    input  logic [4:0]  grfWa_W,
    input  logic [4:0]  tNew_E,
    input  logic [4:0]  tNew_M,
    input  logic        mduUse_D,
    input  logic        mduStart_E,
    input  logic        mduIsDiv_E,
    output logic        stall_Pc,
    output logic        stall_IfId,
    output logic        flush_IdEx,
    output logic [1:0]  fwdRs_D,
    output logic [1:0]  fwdRt_D,
    output logic [1:0]  fwdRs_E,
    output logic [1:0]  fwdRt_E,
    output logic        fwdRt_M,
    output logic        mduBusy,
    output logic [31:0] stallCnt
);

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    localparam logic [1:0] SRC_PIPE = 2'd0;
    localparam logic [1:0] SRC_E    = 2'd1;
    localparam logic [1:0] SRC_M    = 2'd2;
    localparam logic [1:0] SRC_W    = 2'd3;

    typedef enum logic {
        MDU_IDLE = 1'b0,
        MDU_BUSY = 1'b1
    } mdu_state_e;

    mdu_state_e       mdu_state_q;
    logic [CNT_W-1:0] mdu_cnt_q;
    logic             mdu_busy_q;
    logic [31:0]      stall_cnt_q;
    logic [31:0]      stall_cnt_d;

    logic             stall_rs;
    logic             stall_rt;
    logic             stall_mdu;
    logic             stall_any;
    logic [1:0]       fwd_rs_d_raw;
    logic [1:0]       fwd_rt_d_raw;
    logic [1:0]       fwd_rs_e_raw;
    logic [1:0]       fwd_rt_e_raw;
    logic             fwd_rt_m_raw;

    // A writer matches a reader only for a nonzero destination register.
    function automatic logic wr_hit(input logic we, input logic [4:0] wa, input logic [4:0] ra);
        return we && (wa != 5'd0) && (wa == ra);
    endfunction

    // D-stage data hazards: result still in flight longer than the reader can wait.
    always_comb begin
        stall_rs = 1'b0;
        stall_rt = 1'b0;
        if (ifReGrf1_D) begin
            stall_rs = (wr_hit(ifWrGrf_E, grfWa_E, grfRa1_D) && (tNew_E > tUseRs_D)) ||
                       (wr_hit(ifWrGrf_M, grfWa_M, grfRa1_D) && (tNew_M > tUseRs_D));
        end
        if (ifReGrf2_D) begin
            stall_rt = (wr_hit(ifWrGrf_E, grfWa_E, grfRa2_D) && (tNew_E > tUseRt_D)) ||
                       (wr_hit(ifWrGrf_M, grfWa_M, grfRa2_D) && (tNew_M > tUseRt_D));
        end
        stall_mdu = mduUse_D && (mdu_busy_q || mduStart_E);
        stall_any = stall_rs || stall_rt || stall_mdu;
    end

    // Forwarding sources, youngest ready producer first.
    always_comb begin
        fwd_rs_d_raw = SRC_PIPE;
        fwd_rt_d_raw = SRC_PIPE;
        fwd_rs_e_raw = SRC_PIPE;
        fwd_rt_e_raw = SRC_PIPE;
        fwd_rt_m_raw = 1'b0;

        if (wr_hit(ifWrGrf_E, grfWa_E, grfRa1_D) && (tNew_E == 5'd0))      fwd_rs_d_raw = SRC_E;
        else if (wr_hit(ifWrGrf_M, grfWa_M, grfRa1_D) && (tNew_M == 5'd0)) fwd_rs_d_raw = SRC_M;
        else if (wr_hit(ifWrGrf_W, grfWa_W, grfRa1_D))                     fwd_rs_d_raw = SRC_W;

        if (wr_hit(ifWrGrf_E, grfWa_E, grfRa2_D) && (tNew_E == 5'd0))      fwd_rt_d_raw = SRC_E;
        else if (wr_hit(ifWrGrf_M, grfWa_M, grfRa2_D) && (tNew_M == 5'd0)) fwd_rt_d_raw = SRC_M;
        else if (wr_hit(ifWrGrf_W, grfWa_W, grfRa2_D))                     fwd_rt_d_raw = SRC_W;

        // E operands never come from E itself; a non-reading E slot keeps the pipe value.
        if (ifReGrf1_E) begin
            if (wr_hit(ifWrGrf_M, grfWa_M, grfRa1_E) && (tNew_M == 5'd0)) fwd_rs_e_raw = SRC_M;
            else if (wr_hit(ifWrGrf_W, grfWa_W, grfRa1_E))                fwd_rs_e_raw = SRC_W;
        end
        if (ifReGrf2_E) begin
            if (wr_hit(ifWrGrf_M, grfWa_M, grfRa2_E) && (tNew_M == 5'd0)) fwd_rt_e_raw = SRC_M;
            else if (wr_hit(ifWrGrf_W, grfWa_W, grfRa2_E))                fwd_rt_e_raw = SRC_W;
        end

        fwd_rt_m_raw = wr_hit(ifWrGrf_W, grfWa_W, grfRa2_M);
    end

    // Outputs held at 0 for as long as reset is asserted.
    always_comb begin
        stall_Pc   = reset_n && stall_any;
        stall_IfId = reset_n && stall_any;
        flush_IdEx = reset_n && stall_any;
        fwdRs_D    = reset_n ? fwd_rs_d_raw : SRC_PIPE;
        fwdRt_D    = reset_n ? fwd_rt_d_raw : SRC_PIPE;
        fwdRs_E    = reset_n ? fwd_rs_e_raw : SRC_PIPE;
        fwdRt_E    = reset_n ? fwd_rt_e_raw : SRC_PIPE;
        fwdRt_M    = reset_n && fwd_rt_m_raw;
    end

    // MDU busy sequencer; a new start always reloads, even mid-operation.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mdu_state_q <= MDU_IDLE;
            mdu_cnt_q   <= '0;
            mdu_busy_q  <= 1'b0;
        end else if (mduStart_E) begin
            mdu_state_q <= MDU_BUSY;
            mdu_cnt_q   <= mduIsDiv_E ? DIV_LOAD : MULT_LOAD;
            mdu_busy_q  <= 1'b1;
        end else if (mdu_state_q == MDU_BUSY) begin
            if (mdu_cnt_q <= CNT_ONE) begin
                mdu_state_q <= MDU_IDLE;
                mdu_cnt_q   <= '0;
                mdu_busy_q  <= 1'b0;
            end else begin
                mdu_cnt_q   <= mdu_cnt_q - CNT_ONE;
            end
        end
    end

    // Next stall-count value; wraps naturally at 2^32.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_any) stall_cnt_d = stall_cnt_q + 32'd1;
    end

    // Stall-cycle performance counter register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) stall_cnt_q <= '0;
        else          stall_cnt_q <= stall_cnt_d;
    end

    assign mduBusy  = mdu_busy_q;
    assign stallCnt = stall_cnt_q;

endmodule
